// File: rtl/issue_sched_if.sv
// issue_sched_if: handshake/bus bundle between decode, the dual-issue
// scheduler and the launch-select datapath.
//   master : decode/test side, drives the pair, unit readiness, writeback, flush
//   slave  : issue_sched, returns in_ready, launch_flag, buf_state
interface issue_sched_if #(
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic              in1_v,    in2_v;
    logic [1:0]        in1_type, in2_type;
    logic [ADDR_W-1:0] in1_rs,   in1_rt,   in1_rd;
    logic [ADDR_W-1:0] in2_rs,   in2_rt,   in2_rd;
    logic              in1_rs_v, in1_rt_v, in1_rd_v;
    logic              in2_rs_v, in2_rt_v, in2_rd_v;
    logic              in1_long, in2_long;
    logic              exc1_ready, exc2_ready;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic              flush;
    logic [3:0]        launch_flag;
    logic [1:0]        buf_state;

    modport master (
        output in_valid, in1_v, in2_v, in1_type, in2_type,
               in1_rs, in1_rt, in1_rd, in2_rs, in2_rt, in2_rd,
               in1_rs_v, in1_rt_v, in1_rd_v, in2_rs_v, in2_rt_v, in2_rd_v,
               in1_long, in2_long, exc1_ready, exc2_ready,
               wb_valid, wb_addr, flush,
        input  in_ready, launch_flag, buf_state
    );

    modport slave (
        input  in_valid, in1_v, in2_v, in1_type, in2_type,
               in1_rs, in1_rt, in1_rd, in2_rs, in2_rt, in2_rd,
               in1_rs_v, in1_rt_v, in1_rd_v, in2_rs_v, in2_rt_v, in2_rd_v,
               in1_long, in2_long, exc1_ready, exc2_ready,
               wb_valid, wb_addr, flush,
        output in_ready, launch_flag, buf_state
    );
endinterface

// File: rtl/issue_sched.sv
// issue_sched: dual-issue scheduler. Buffers one decoded pair, tracks
// in-flight long (writeback-only) results in a busy scoreboard and decides
// each cycle which buffered instruction launches on which unit
// (exc1 = arithmetic/branch, exc2 = address-gen/memory).
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   bus (slave)   pair input + in_ready, unit readiness, writeback,
//                 flush, launch_flag[3:0], buf_state[1:0]
// Build option: define ISSUE_DUAL_EN to allow both instructions of a pair
// to launch in the same cycle; otherwise at most one launches per cycle.
module issue_sched #(
    parameter int         REG_NUM     = 32,
    parameter int         ADDR_W      = 5,
    parameter logic [1:0] INSTTYPE_AG = 2'b01
) (
    input  logic         clk,
    input  logic         rst_n,
    issue_sched_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        BOTH   = 2'b01,
        SECOND = 2'b10
    } state_t;

    typedef struct packed {
        logic              v;
        logic [1:0]        typ;
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
        logic [ADDR_W-1:0] rd;
        logic              rs_v;
        logic              rt_v;
        logic              rd_v;
        logic              lng;
    } inst_t;

    state_t             state_q, state_d;
    inst_t              b1_q, b2_q;
    logic [REG_NUM-1:0] busy_q, busy_d;

    logic pend1, pend2, ag1, ag2, rdy1, rdy2, ok1, ok2;
    logic iss1, iss2, dual_ok, all_issue, accept;

    // RAW on either used source or WAW on the used destination.
    function automatic logic hazard(input inst_t i, input logic [REG_NUM-1:0] b);
        return (i.rs_v && b[i.rs]) || (i.rt_v && b[i.rt]) || (i.rd_v && b[i.rd]);
    endfunction

    always_comb begin
        pend1 = (state_q == BOTH) && b1_q.v;
        pend2 = ((state_q == BOTH) && b2_q.v) || (state_q == SECOND);
        ag1   = (b1_q.typ == INSTTYPE_AG);
        ag2   = (b2_q.typ == INSTTYPE_AG);
        rdy1  = ag1 ? bus.exc2_ready : bus.exc1_ready;
        rdy2  = ag2 ? bus.exc2_ready : bus.exc1_ready;
        ok1   = pend1 && rdy1 && !hazard(b1_q, busy_q) && !bus.flush;
        ok2   = pend2 && rdy2 && !hazard(b2_q, busy_q) && !bus.flush;
`ifdef ISSUE_DUAL_EN
        // inst2 must not see inst1's result in the same cycle, and the two
        // must use different units.
        dual_ok = (ag1 != ag2) && !(b1_q.rd_v &&
                  ((b2_q.rs_v && (b2_q.rs == b1_q.rd)) ||
                   (b2_q.rt_v && (b2_q.rt == b1_q.rd)) ||
                   (b2_q.rd_v && (b2_q.rd == b1_q.rd))));
`else
        dual_ok = 1'b0;
`endif
        iss1 = ok1;
        // In-order: inst2 goes only once inst1 is out (or leaves with it).
        iss2 = ok2 && ((state_q == SECOND) || !pend1 || (iss1 && dual_ok));

        all_issue = (state_q == EMPTY) ||
                    ((state_q == BOTH) && (!pend1 || iss1) && (!b2_q.v || iss2)) ||
                    ((state_q == SECOND) && iss2);

        bus.in_ready    = !bus.flush && all_issue;
        accept          = bus.in_valid && bus.in_ready;
        bus.launch_flag = {iss1 && !ag1, iss1 && ag1, iss2 && !ag2, iss2 && ag2};

        if (bus.flush)                            state_d = EMPTY;
        else if (accept)                          state_d = BOTH;
        else if (all_issue)                       state_d = EMPTY;
        else if ((state_q == BOTH) && iss1)       state_d = SECOND;
        else                                      state_d = state_q;

        // Clear first so a same-register set in the same cycle wins.
        busy_d = busy_q;
        if (bus.wb_valid)
            busy_d[bus.wb_addr] = 1'b0;
        if (iss1 && b1_q.lng && b1_q.rd_v)
            busy_d[b1_q.rd] = 1'b1;
        if (iss2 && b2_q.lng && b2_q.rd_v)
            busy_d[b2_q.rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    assign bus.buf_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            b1_q    <= '0;
            b2_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                b1_q <= '{v: bus.in1_v, typ: bus.in1_type, rs: bus.in1_rs,
                          rt: bus.in1_rt, rd: bus.in1_rd, rs_v: bus.in1_rs_v,
                          rt_v: bus.in1_rt_v, rd_v: bus.in1_rd_v, lng: bus.in1_long};
                b2_q <= '{v: bus.in2_v, typ: bus.in2_type, rs: bus.in2_rs,
                          rt: bus.in2_rt, rd: bus.in2_rd, rs_v: bus.in2_rs_v,
                          rt_v: bus.in2_rt_v, rd_v: bus.in2_rd_v, lng: bus.in2_long};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

endmodule

// File: tb/tb_issue_sched.sv
// tb_issue_sched: directed vectors for issue_sched. Each driven cycle pushes
// its hand-computed {launch_flag, in_ready, buf_state} onto a queue; the
// negedge monitor pops and compares.
module tb_issue_sched;

    localparam logic [1:0] ALU = 2'b00;
    localparam logic [1:0] AG  = 2'b01;

    logic clk = 1'b1;
    logic rst_n;
    always #5 clk = ~clk;

    issue_sched_if #(.ADDR_W(5)) bus ();

    issue_sched #(.REG_NUM(32), .ADDR_W(5), .INSTTYPE_AG(2'b01)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string      nm;
        logic [3:0] lf;
        logic       rdy;
        logic [1:0] st;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if (bus.launch_flag !== e.lf || bus.in_ready !== e.rdy || bus.buf_state !== e.st) begin
                n_bad++;
                $display("FAIL %s: got lf=%b rdy=%b st=%0d, want lf=%b rdy=%b st=%0d",
                         e.nm, bus.launch_flag, bus.in_ready, bus.buf_state,
                         e.lf, e.rdy, e.st);
            end
        end
    end

    // Push this cycle's expectation, then step to just after the next edge.
    task automatic cyc(input string nm, input logic [3:0] lf, input logic rdy,
                       input logic [1:0] st);
        exp_t e;
        e.nm = nm; e.lf = lf; e.rdy = rdy; e.st = st;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_i1(input logic [1:0] t, input int rs, input logic rsv,
                          input int rt, input logic rtv, input int rd,
                          input logic rdv, input logic lng);
        bus.in1_v = 1'b1; bus.in1_type = t;
        bus.in1_rs = 5'(rs); bus.in1_rs_v = rsv;
        bus.in1_rt = 5'(rt); bus.in1_rt_v = rtv;
        bus.in1_rd = 5'(rd); bus.in1_rd_v = rdv;
        bus.in1_long = lng;
    endtask

    task automatic set_i2(input logic v, input logic [1:0] t, input int rs,
                          input logic rsv, input int rt, input logic rtv,
                          input int rd, input logic rdv, input logic lng);
        bus.in2_v = v; bus.in2_type = t;
        bus.in2_rs = 5'(rs); bus.in2_rs_v = rsv;
        bus.in2_rt = 5'(rt); bus.in2_rt_v = rtv;
        bus.in2_rd = 5'(rd); bus.in2_rd_v = rdv;
        bus.in2_long = lng;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_addr = '0;
        bus.exc1_ready = 1'b1; bus.exc2_ready = 1'b1;
        set_i1(ALU, 0, 0, 0, 0, 0, 0, 0);
        set_i2(0, ALU, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        cyc("reset0", 4'b0000, 1'b1, 2'd0);
        cyc("reset1", 4'b0000, 1'b1, 2'd0);
        rst_n = 1'b1;
        cyc("idle", 4'b0000, 1'b1, 2'd0);

        // 1: independent ALU + AG pair
        bus.in_valid = 1'b1;
        set_i1(ALU, 2, 1, 0, 0, 1, 1, 0);
        set_i2(1, AG, 3, 1, 0, 0, 4, 1, 0);
        cyc("p1_accept", 4'b0000, 1'b1, 2'd0);
        bus.in_valid = 1'b0;
`ifdef ISSUE_DUAL_EN
        cyc("p1_dual", 4'b1001, 1'b1, 2'd1);
        cyc("p1_empty", 4'b0000, 1'b1, 2'd0);
`else
        cyc("p1_first", 4'b1000, 1'b0, 2'd1);
        cyc("p1_second", 4'b0001, 1'b1, 2'd2);
        cyc("p1_empty", 4'b0000, 1'b1, 2'd0);
`endif

        // 2: long load r5, inst2 reads r5
        bus.in_valid = 1'b1;
        set_i1(AG, 0, 0, 0, 0, 5, 1, 1);
        set_i2(1, ALU, 5, 1, 0, 0, 6, 1, 0);
        cyc("p2_accept", 4'b0000, 1'b1, 2'd0);
        bus.in_valid = 1'b0;
        cyc("p2_load", 4'b0100, 1'b0, 2'd1);
        cyc("p2_raw0", 4'b0000, 1'b0, 2'd2);
        cyc("p2_raw1", 4'b0000, 1'b0, 2'd2);
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd5;
        cyc("p2_wb_nobypass", 4'b0000, 1'b0, 2'd2);
        bus.wb_valid = 1'b0;
        cyc("p2_dep", 4'b0010, 1'b1, 2'd2);
        cyc("p2_empty", 4'b0000, 1'b1, 2'd0);

        // 3: two ALU ops share exc1
        bus.in_valid = 1'b1;
        set_i1(ALU, 0, 0, 0, 0, 8, 1, 0);
        set_i2(1, ALU, 0, 0, 0, 0, 9, 1, 0);
        cyc("p3_accept", 4'b0000, 1'b1, 2'd0);
        bus.in_valid = 1'b0;
        cyc("p3_first", 4'b1000, 1'b0, 2'd1);
        cyc("p3_second", 4'b0010, 1'b1, 2'd2);
        bus.in_valid = 1'b1;
        set_i1(ALU, 1, 1, 0, 0, 15, 1, 0);
        set_i2(1, ALU, 0, 0, 0, 0, 16, 1, 0);
        cyc("p3b_accept", 4'b0000, 1'b1, 2'd0);
        bus.in_valid = 1'b0;
        bus.exc1_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc("p3b_stall", 4'b0000, 1'b0, 2'd1);
        bus.exc1_ready = 1'b1;
        cyc("p3b_first", 4'b1000, 1'b0, 2'd1);
        // drain and accept an inst1-only pair in the same cycle
        bus.in_valid = 1'b1;
        set_i1(ALU, 0, 0, 0, 0, 10, 1, 0);
        set_i2(0, ALU, 0, 0, 0, 0, 0, 0, 0);
        cyc("p3b_second_acc", 4'b0010, 1'b1, 2'd2);
        bus.in_valid = 1'b0;
        cyc("p3c_single", 4'b1000, 1'b1, 2'd1);
        cyc("p3c_empty", 4'b0000, 1'b1, 2'd0);

        // 4: flush in SECOND, busy r7 survives
        bus.in_valid = 1'b1;
        set_i1(AG, 0, 0, 0, 0, 7, 1, 1);
        set_i2(1, ALU, 0, 0, 7, 1, 11, 1, 0);
        cyc("p4_accept", 4'b0000, 1'b1, 2'd0);
        bus.in_valid = 1'b0;
        cyc("p4_load", 4'b0100, 1'b0, 2'd1);
        bus.flush = 1'b1;
        cyc("p4_flush", 4'b0000, 1'b0, 2'd2);
        bus.flush = 1'b0;
        bus.in_valid = 1'b1;
        set_i1(ALU, 7, 1, 0, 0, 12, 1, 0);
        set_i2(0, ALU, 0, 0, 0, 0, 0, 0, 0);
        cyc("p4_after_flush", 4'b0000, 1'b1, 2'd0);
        bus.in_valid = 1'b0;
        cyc("p4_r7_busy", 4'b0000, 1'b0, 2'd1);
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd7;
        cyc("p4_wb7", 4'b0000, 1'b0, 2'd1);
        bus.wb_valid = 1'b0;
        cyc("p4_r7_free", 4'b1000, 1'b1, 2'd1);
        cyc("p4_empty", 4'b0000, 1'b1, 2'd0);

        // 5a: long op to r3 issues while wb_valid hits r3: set wins
        bus.in_valid = 1'b1;
        set_i1(ALU, 0, 0, 0, 0, 3, 1, 1);
        set_i2(1, AG, 3, 1, 0, 0, 13, 1, 0);
        cyc("p5_accept", 4'b0000, 1'b1, 2'd0);
        bus.in_valid = 1'b0;
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd3;
        cyc("p5_set_vs_clr", 4'b1000, 1'b0, 2'd1);
        bus.wb_valid = 1'b0;
        cyc("p5_r3_busy", 4'b0000, 1'b0, 2'd2);
        bus.wb_valid = 1'b1;
        cyc("p5_wb3", 4'b0000, 1'b0, 2'd2);
        bus.wb_valid = 1'b0;
        cyc("p5_r3_free", 4'b0001, 1'b1, 2'd2);
        cyc("p5_empty", 4'b0000, 1'b1, 2'd0);

        // 5b: long op to r0 never marks r0 busy
        bus.in_valid = 1'b1;
        set_i1(ALU, 0, 0, 0, 0, 0, 1, 1);
        set_i2(1, AG, 0, 1, 0, 0, 14, 1, 0);
        cyc("p5b_accept", 4'b0000, 1'b1, 2'd0);
        bus.in_valid = 1'b0;
        cyc("p5b_first", 4'b1000, 1'b0, 2'd1);
        cyc("p5b_r0_free", 4'b0001, 1'b1, 2'd2);
        cyc("p5b_empty", 4'b0000, 1'b1, 2'd0);

        // 6: asynchronous reset mid-SECOND
        bus.in_valid = 1'b1;
        set_i1(AG, 0, 0, 0, 0, 20, 1, 1);
        set_i2(1, ALU, 20, 1, 0, 0, 21, 1, 0);
        cyc("p6_accept", 4'b0000, 1'b1, 2'd0);
        bus.in_valid = 1'b0;
        cyc("p6_load", 4'b0100, 1'b0, 2'd1);
        cyc("p6_second", 4'b0000, 1'b0, 2'd2);
        rst_n = 1'b0;
        cyc("p6_async_rst", 4'b0000, 1'b1, 2'd0);
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        set_i1(ALU, 20, 1, 0, 0, 22, 1, 0);
        set_i2(0, ALU, 0, 0, 0, 0, 0, 0, 0);
        cyc("p6_accept2", 4'b0000, 1'b1, 2'd0);
        bus.in_valid = 1'b0;
        cyc("p6_busy_cleared", 4'b1000, 1'b1, 2'd1);
        cyc("p6_empty", 4'b0000, 1'b1, 2'd0);

        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/issue_sched.md
# issue_sched

Dual-issue scheduler between the decode pair buffer and the launch-select datapath. Holds one decoded instruction pair and tracks in-flight multi-cycle register writes in a scoreboard. Each cycle it decides which buffered instruction goes to which execution unit (exc1: arithmetic/branch, exc2: address-generation/memory), honouring in-order issue, unit readiness and RAW/WAW hazards. Its `launch_flag` drives the launch-select muxes directly.

## Interface
Parameters:
- `REG_NUM`, 32, number of architectural registers; must be 2**`ADDR_W`
- `ADDR_W`, 5, register address width
- `INSTTYPE_AG`, 2'b01, instruction-type code routed to exc2

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `in_valid`  in  1  decode offers a pair this cycle
- `in_ready`  out  1  pair accepted at the edge when `in_valid & in_ready`
- `in1_v`, `in2_v`  in  1 each  slot holds a real instruction; a pair with only `in1_v` is legal
- `in1_type`, `in2_type`  in  2 each  instruction type
- `in1_rs`, `in1_rt`, `in1_rd`, `in2_rs`, `in2_rt`, `in2_rd`  in  `ADDR_W` each  register addresses
- `in1_rs_v`, `in1_rt_v`, `in1_rd_v`, `in2_rs_v`, `in2_rt_v`, `in2_rd_v`  in  1 each  field used
- `in1_long`, `in2_long`  in  1 each  result arrives via writeback only, with no bypass (load, mul/div)
- `exc1_ready`, `exc2_ready`  in  1 each  execution unit accepts an instruction this cycle
- `wb_valid`  in  1  a long result is written back this cycle
- `wb_addr`  in  `ADDR_W`  destination being written back
- `flush`  in  1  discard buffered pair (branch redirect)
- `launch_flag`  out  4  [3] inst1→exc1, [2] inst1→exc2, [1] inst2→exc1, [0] inst2→exc2
- `buf_state`  out  2  FSM state, for debug and performance counters

## Operation
- FSM states:
  - EMPTY=2'b00
  - BOTH=2'b01: inst1 and, if `in2_v`, inst2 pending
  - SECOND=2'b10: inst1 issued, inst2 pending
- Transitions:
  - EMPTY→BOTH on accept.
  - BOTH→SECOND when inst1 issues and inst2 is valid but does not issue.
  - BOTH→EMPTY when everything pending issues.
  - SECOND→EMPTY when inst2 issues.
  - EMPTY/BOTH/SECOND→BOTH on accept in the same cycle the buffer drains.
- Unit select: `type==INSTTYPE_AG` → exc2, otherwise exc1.
- An instruction can issue when all of the following hold:
  - it is pending;
  - its unit's ready is high;
  - no used source is marked busy;
  - its used rd is not busy (WAW).
- inst2 may issue only if inst1 has already issued or issues this cycle (in-order).
- Same-cycle pair issue additionally requires:
  - different units;
  - inst1 does not write a register inst2 reads or writes (when `in1_rd_v`).
- `launch_flag` is combinational from buffer contents, the scoreboard, readiness and `flush`. At most one bit per instruction and one bit per unit is set. It is 4'b0000 when `flush` is high.
- Scoreboard `busy[REG_NUM-1:0]`:
  - Set on issue of a `long` instruction with `rd_v` and rd≠0.
  - Cleared by `wb_valid` at `wb_addr`.
  - If set and clear hit the same register in the same cycle, set wins.
  - Register 0 is never busy.
  - A writeback clears the busy bit at the edge only; there is no same-cycle wb→issue bypass.
- `in_ready` = (state==EMPTY) or (all pending instructions issue this cycle). It is forced low during `flush`.
- `flush`: state→EMPTY at the edge and no new pair is accepted that cycle. The scoreboard is untouched, because in-flight long ops still write back.

## Timing
- Reset values: state EMPTY, all buffer fields 0, `busy` all 0. With no pair pending: `launch_flag`=0, `in_ready`=1, `buf_state`=0.
- Accept-to-issue latency ≥1 cycle: a pair accepted at edge N can first issue in cycle N+1.
- Busy bit set at edge N blocks dependents from cycle N+1. `wb_valid` at edge M unblocks from cycle M+1.
- Reset mid-operation: buffer and scoreboard are discarded immediately (asynchronous).

## Configuration
- `ISSUE_DUAL_EN` defined: same-cycle pair issue is allowed under the rules above.
- `ISSUE_DUAL_EN` undefined: at most one `launch_flag` bit is set per cycle. inst2 always issues in a later cycle than inst1, so a full pair takes ≥2 cycles. All other rules are unchanged.

## Test plan
- Independent ALU + AG pair, both units ready, `ISSUE_DUAL_EN` on → cycle after accept `launch_flag`=4'b1001, state back to EMPTY; with macro off → 4'b1000 then 4'b0001.
- Pair with inst1 `long` load writing r5 and inst2 reading r5 → 4'b0100, then 0 until `wb_valid` with `wb_addr`=5; the cycle after → 4'b0010.
- Both instructions ALU type → 4'b1000, then next cycle 4'b0010. With `exc1_ready`=0 for 3 cycles, `launch_flag`=0 and `in_ready`=0 throughout.
- `flush` while in SECOND → `launch_flag`=0, next cycle state EMPTY, `in_ready`=1. A busy bit on r7 is still set until its writeback.
- Issue of a long op to r3 coinciding with `wb_valid` on r3 → `busy[3]`=1 afterwards. Long op to r0 → `busy[0]` stays 0.
- Assert `rst_n` low mid-SECOND → state EMPTY, `busy`=0, `launch_flag`=0 immediately.
